mips_multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the 16-bit mini MIPS datapath. Steps each instruction through

---
 rtl/mips_multicycle_ctrl.sv | 85 ++++++++
 tb/tb_mips_multicycle_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit mini MIPS datapath.
module mips_multicycle_ctrl #(
  parameter int CNT_W = 16,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W = 4
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             run,
  input  logic [3:0]       op,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic [2:0]       alu_op,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [2:0]       state,
  output logic             retired,
  output logic [CNT_W-1:0] instr_count,
  output logic [1:0]       trap
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t st;
  logic [TO_W-1:0] wait_cnt;
  logic is_lw, is_sw, is_br, is_j, taken, waiting, timeout;
  always_comb begin
    is_lw = op == 4'd4;
    is_sw = op == 4'd5;
    is_br = op == 4'd6 || op == 4'd7;
    is_j = op == 4'd8;
    taken = (op == 4'd6 && zero) || (op == 4'd7 && !zero);
    waiting = (st == FETCH && !imem_ready) || (st == MEM && !dmem_ready);
    timeout = waiting && wait_cnt == TO_W'(MEM_TIMEOUT - 1);
    retired = (st == EXEC && (is_br || is_j)) || (st == MEM && is_sw && dmem_ready) || st == WB;
    imem_req = st == FETCH;
    ir_write = st == FETCH && imem_ready;
    pc_write = ir_write || (st == EXEC && (is_j || taken));
    pc_src = st == EXEC ? (is_j ? 2'b10 : {1'b0, taken}) : 2'b00;
    reg_write = st == WB;
    reg_dst = st == WB && op == 4'd0;
    mem_to_reg = st == WB && is_lw;
    alu_src = (st == EXEC && op >= 4'd1 && op <= 4'd5) || st == MEM || (st == WB && is_lw);
    alu_op = st != EXEC ? 3'b000 :
             op == 4'd0 ? 3'b010 :
             op == 4'd2 ? 3'b011 :
             op == 4'd3 ? 3'b100 :
             is_br      ? 3'b001 : 3'b000;
    dmem_read = st == MEM && is_lw;
    dmem_write = st == MEM && is_sw;
    state = st;
  end
  // wait_cnt is zero on entry to FETCH/MEM because every other state clears it
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      wait_cnt <= '0;
      instr_count <= '0;
      trap <= 2'b00;
    end else begin
      wait_cnt <= waiting ? wait_cnt + 1'b1 : '0;
      if (retired) instr_count <= instr_count + 1'b1;
      if (timeout) trap <= 2'b10;
      if (st == DECODE && op >= 4'd9) trap <= 2'b01;
      if (timeout) st <= HALT;
      else if (retired) st <= run ? FETCH : IDLE;
      else
        case (st)
          IDLE:    st <= run ? FETCH : IDLE;
          FETCH:   st <= imem_ready ? DECODE : FETCH;
          DECODE:  st <= op >= 4'd9 ? HALT : EXEC;
          EXEC:    st <= (is_lw || is_sw) ? MEM : WB;
          MEM:     st <= dmem_ready ? WB : MEM;
          default: st <= st;
        endcase
    end
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: randomized phase-sequence model checks for the multi-cycle controller.
module tb_mips_multicycle_ctrl;
  localparam int CW = 4;
  logic clock = 0, rst_n = 0, run = 0, zero = 0, imem_ready = 0, dmem_ready = 0;
  logic [3:0] op = 0;
  logic imem_req, ir_write, pc_write, reg_write, reg_dst, alu_src, mem_to_reg;
  logic dmem_read, dmem_write, retired;
  logic [1:0] pc_src, trap;
  logic [2:0] alu_op, state;
  logic [CW-1:0] instr_count;
  int total = 0, bad = 0, model_cnt = 0;
  localparam logic [2:0] ALU_TAB [0:7] = '{3'd2, 3'd0, 3'd3, 3'd4, 3'd0, 3'd0, 3'd1, 3'd1};
  localparam logic SRC_TAB [0:7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  mips_multicycle_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(15), .TO_W(4)) dut (
    .clock(clock), .rst_n(rst_n), .run(run), .op(op), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .state(state), .retired(retired),
    .instr_count(instr_count), .trap(trap));

  always #5 clock = ~clock;

  task automatic apply_reset();
    @(negedge clock);
    rst_n = 0;
    run = 0;
    #1;
    model_cnt = 0;
    total++;
    if ({state, trap, instr_count} !== '0) begin
      bad++;
      $display("FAIL reset_regs state=%0d trap=%0d cnt=%0d want 0", state, trap, instr_count);
    end
    @(negedge clock);
    rst_n = 1;
  endtask

  task automatic go_idle();
    @(negedge clock);
    run = 1;
    #1;
    total++;
    if (state !== 3'd0) begin
      bad++;
      $display("FAIL idle_start state=%0d want 0", state);
    end
  endtask

  // One instruction: expected per-cycle phase list comes from opcode class and wait counts
  task automatic do_instr(input logic [3:0] o, input logic z, input int iw, input int dw, input logic stop);
    int ph[$];
    int n_f, n_m;
    logic lw, sw, j, tk;
    n_f = 0;
    n_m = 0;
    lw = o == 4;
    sw = o == 5;
    j = o == 8;
    tk = j || (o == 6 && z) || (o == 7 && !z);
    for (int i = 0; i <= iw; i++) ph.push_back(1);
    ph.push_back(2);
    ph.push_back(3);
    if (lw || sw) for (int i = 0; i <= dw; i++) ph.push_back(4);
    if (o <= 3 || lw) ph.push_back(5);
    foreach (ph[k]) begin
      logic last, fr, epw;
      logic [10:0] e, a;
      @(negedge clock);
      last = k == ph.size() - 1;
      fr = ph[k] == 1 && n_f == iw;
      epw = fr || (ph[k] == 3 && tk);
      op = o;
      zero = ph[k] == 3 ? z : 1'($urandom);
      run = !(stop && ph[k] >= 3);
      imem_ready = ph[k] == 1 ? fr : 1'($urandom);
      dmem_ready = ph[k] == 4 ? (n_m == dw) : 1'($urandom);
      #1;
      e = {3'(ph[k]), ph[k] == 1, fr, epw, ph[k] == 5, ph[k] == 4 && lw, ph[k] == 4 && sw, ph[k] == 5 && lw, last};
      a = {state, imem_req, ir_write, pc_write, reg_write, dmem_read, dmem_write, mem_to_reg, retired};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle op=%0d phase=%0d got=%b want=%b", o, ph[k], a, e);
      end
      total++;
      if (instr_count !== CW'(model_cnt)) begin
        bad++;
        $display("FAIL count op=%0d got=%0d want=%0d", o, instr_count, model_cnt);
      end
      if (epw) begin
        total++;
        if (pc_src !== (fr ? 2'b00 : j ? 2'b10 : 2'b01)) begin
          bad++;
          $display("FAIL pc_src op=%0d phase=%0d got=%b", o, ph[k], pc_src);
        end
      end
      if (ph[k] == 3 && !j) begin
        total++;
        if ({alu_op, alu_src} !== {ALU_TAB[o[2:0]], SRC_TAB[o[2:0]]}) begin
          bad++;
          $display("FAIL exec_alu op=%0d got=%0d/%b want=%0d/%b", o, alu_op, alu_src, ALU_TAB[o[2:0]], SRC_TAB[o[2:0]]);
        end
      end
      if (ph[k] == 4) begin
        total++;
        if ({alu_op, alu_src} !== 4'b0001) begin
          bad++;
          $display("FAIL mem_alu got=%0d/%b want=0/1", alu_op, alu_src);
        end
      end
      if (ph[k] == 5) begin
        total++;
        if (reg_dst !== (o == 0)) begin
          bad++;
          $display("FAIL reg_dst op=%0d got=%b", o, reg_dst);
        end
      end
      if (ph[k] == 1) n_f++;
      if (ph[k] == 4) n_m++;
      if (last) model_cnt = (model_cnt + 1) % (1 << CW);
    end
    if (stop) begin
      @(negedge clock);
      run = 0;
      #1;
      total++;
      if ({state, retired} !== 4'b0000 || instr_count !== CW'(model_cnt)) begin
        bad++;
        $display("FAIL stop_idle state=%0d retired=%b cnt=%0d want 0/0/%0d", state, retired, instr_count, model_cnt);
      end
      @(negedge clock);
      run = 1;
      #1;
      total++;
      if (state !== 3'd0) begin
        bad++;
        $display("FAIL stop_resume state=%0d want 0", state);
      end
    end
  endtask

  task automatic peek_count(input int want, input string nm);
    @(negedge clock);
    imem_ready = 0;
    #1;
    total++;
    if (instr_count !== CW'(want) || state !== 3'd1) begin
      bad++;
      $display("FAIL %s cnt=%0d state=%0d want %0d/1", nm, instr_count, state, want);
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({state, imem_req, ir_write, pc_write, reg_write, dmem_read, dmem_write, retired, alu_op, trap, instr_count} !== '0) begin
      bad++;
      $display("FAIL reset_outputs state=%0d alu_op=%0d trap=%0d cnt=%0d want all 0", state, alu_op, trap, instr_count);
    end
    @(negedge clock);
    rst_n = 1;
    run = 0;
    repeat (2) begin
      @(negedge clock);
      #1;
      total++;
      if (state !== 3'd0 || imem_req !== 1'b0) begin
        bad++;
        $display("FAIL idle_hold state=%0d imem_req=%b want 0/0", state, imem_req);
      end
    end
  endtask

  task automatic test_rtype();
    apply_reset();
    go_idle();
    do_instr(4'd0, 1'b0, 0, 0, 1'b0);
    peek_count(1, "rtype_count");
  endtask

  task automatic test_lw_wait();
    apply_reset();
    go_idle();
    do_instr(4'd4, 1'b0, 0, 3, 1'b0);
    do_instr(4'd5, 1'b0, 2, 1, 1'b0);
    peek_count(2, "lw_sw_count");
  endtask

  task automatic test_branch();
    apply_reset();
    go_idle();
    do_instr(4'd6, 1'b1, 0, 0, 1'b0);
    do_instr(4'd6, 1'b0, 0, 0, 1'b0);
    do_instr(4'd7, 1'b0, 0, 0, 1'b0);
    do_instr(4'd7, 1'b1, 0, 0, 1'b0);
    do_instr(4'd8, 1'b0, 0, 0, 1'b0);
    peek_count(5, "branch_count");
  endtask

  task automatic test_ready_boundary();
    apply_reset();
    go_idle();
    do_instr(4'd1, 1'b0, 14, 0, 1'b0);
    do_instr(4'd4, 1'b0, 0, 14, 1'b0);
    peek_count(2, "boundary_count");
  endtask

  task automatic test_stop();
    apply_reset();
    go_idle();
    do_instr(4'd2, 1'b0, 0, 0, 1'b1);
    do_instr(4'd5, 1'b0, 1, 2, 1'b1);
    do_instr(4'd7, 1'b0, 0, 0, 1'b1);
    peek_count(3, "stop_count");
  endtask

  task automatic test_timeout();
    apply_reset();
    go_idle();
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      imem_ready = 0;
      #1;
      total++;
      if (state !== 3'd1 || imem_req !== 1'b1) begin
        bad++;
        $display("FAIL to_wait i=%0d state=%0d req=%b want 1/1", i, state, imem_req);
      end
    end
    repeat (3) begin
      @(negedge clock);
      imem_ready = 1;
      dmem_ready = 1;
      #1;
      total++;
      if (state !== 3'd6 || trap !== 2'b10 || {imem_req, ir_write, pc_write, reg_write, dmem_read, dmem_write, retired} !== '0) begin
        bad++;
        $display("FAIL to_halt state=%0d trap=%0d req=%b want 6/2/0", state, trap, imem_req);
      end
    end
    apply_reset();
    total++;
    if (trap !== 2'b00) begin
      bad++;
      $display("FAIL to_clear trap=%0d want 0", trap);
    end
    go_idle();
    @(negedge clock);
    imem_ready = 1;
    @(negedge clock);
    op = 4'd4;
    @(negedge clock);
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      dmem_ready = 0;
      #1;
      total++;
      if (state !== 3'd4 || dmem_read !== 1'b1) begin
        bad++;
        $display("FAIL dto_wait i=%0d state=%0d rd=%b want 4/1", i, state, dmem_read);
      end
    end
    @(negedge clock);
    #1;
    total++;
    if (state !== 3'd6 || trap !== 2'b10 || dmem_read !== 1'b0 || reg_write !== 1'b0) begin
      bad++;
      $display("FAIL dto_halt state=%0d trap=%0d rd=%b want 6/2/0", state, trap, dmem_read);
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    go_idle();
    @(negedge clock);
    op = 4'hC;
    imem_ready = 1;
    dmem_ready = 1;
    @(negedge clock);
    #1;
    total++;
    if (state !== 3'd2 || trap !== 2'b00) begin
      bad++;
      $display("FAIL ill_decode state=%0d trap=%0d want 2/0", state, trap);
    end
    repeat (4) begin
      @(negedge clock);
      #1;
      total++;
      if (state !== 3'd6 || trap !== 2'b01 || {reg_write, dmem_read, dmem_write, retired, imem_req} !== '0) begin
        bad++;
        $display("FAIL ill_halt state=%0d trap=%0d strobes=%b want 6/1/0", state, trap, {reg_write, dmem_read, dmem_write, retired, imem_req});
      end
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    go_idle();
    @(negedge clock);
    imem_ready = 1;
    @(negedge clock);
    op = 4'd8;
    @(negedge clock);
    #1;
    total++;
    if (retired !== 1'b1 || pc_write !== 1'b1) begin
      bad++;
      $display("FAIL mid_exec retired=%b pc_write=%b want 1/1", retired, pc_write);
    end
    rst_n = 0;
    #1;
    total++;
    if ({retired, pc_write, state} !== '0) begin
      bad++;
      $display("FAIL mid_async retired=%b pc_write=%b state=%0d want 0", retired, pc_write, state);
    end
    @(negedge clock);
    rst_n = 1;
    run = 0;
    #1;
    total++;
    if (instr_count !== '0) begin
      bad++;
      $display("FAIL mid_count cnt=%0d want 0", instr_count);
    end
  endtask

  task automatic test_random();
    apply_reset();
    go_idle();
    for (int n = 0; n < 40; n++) begin
      int iw, dw;
      iw = ($urandom % 8 == 0) ? 14 : int'($urandom % 4);
      dw = ($urandom % 8 == 0) ? 14 : int'($urandom % 4);
      do_instr(4'($urandom % 9), 1'($urandom), iw, dw, $urandom % 5 == 0);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    go_idle();
    for (int n = 0; n < 17; n++) do_instr(4'($urandom % 9), 1'($urandom), 0, 0, 1'b0);
    peek_count(1, "wrap_count");
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch();
    test_ready_boundary();
    test_stop();
    test_timeout();
    test_illegal();
    test_mid_reset();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
